// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC/branch unit: op codes, ALU flag indices and
// the condition evaluator used by the conditional jumps.
package pc_branch_unit_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_JMP  = 3'd2,
    OP_JZ   = 3'd3,
    OP_JNZ  = 3'd4,
    OP_JC   = 3'd5,
    OP_CALL = 3'd6,
    OP_RET  = 3'd7
  } op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  // True when a conditional jump should be taken; false for every other op.
  function automatic logic cond_true(input op_e op, input logic [1:0] flags);
    logic res;
    case (op)
      OP_JZ:   res = flags[FLAG_Z];
      OP_JNZ:  res = ~flags[FLAG_Z];
      OP_JC:   res = flags[FLAG_C];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_branch_unit_ret_stack.sv
// Return-address LIFO. Refuses push when full and pop when empty, flagging the
// refusal so the caller can record a fault; refused requests change nothing.
module ret_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  parameter int SPW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [SPW-1:0]   sp_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             refused_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic [AW-1:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (r_sp == SPW'(DEPTH));
  assign empty_o   = (r_sp == '0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;
  assign refused_o = (push_i & full_o) | (pop_i & empty_o);
  // Low bits of sp-1 address the top entry, including sp==DEPTH.
  assign w_top_idx = r_sp[AW-1:0] - AW'(1);
  assign top_o     = r_mem[w_top_idx];
  assign sp_o      = r_sp;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  // Entries are deliberately not reset; anything above sp is unreachable.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_sp[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with next-PC selection, condition evaluation and a
// hardware return stack; one control op is applied per enabled cycle.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int          PC_W      = 12,
  parameter int          DEPTH     = 4,
  parameter int unsigned RESET_VEC = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [2:0]                 op_i,
  input  logic [PC_W-1:0]            target_i,
  input  logic [1:0]                 flags_i,
  output logic [PC_W-1:0]            pc_o,
  output logic                       taken_o,
  output logic [$clog2(DEPTH):0]     sp_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       fault_o
);

  localparam int SPW = $clog2(DEPTH) + 1;

  op_e             w_op;
  logic [PC_W-1:0] r_pc;
  logic            r_taken;
  logic            r_fault;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_top;
  logic            w_taken;
  logic            w_push;
  logic            w_pop;
  logic            w_refused;
  logic            w_full;
  logic            w_empty;

  assign w_op     = op_e'(op_i);
  assign w_pc_inc = r_pc + PC_W'(1);

  ret_stack #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH),
    .SPW   (SPW)
  ) u_ret_stack (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_push),
    .pop_i     (w_pop),
    .data_i    (w_pc_inc),
    .top_o     (w_top),
    .sp_o      (sp_o),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .refused_o (w_refused)
  );

  // Blocked CALL/RET fall through to pc+1 without changing flow.
  always_comb begin
    w_next_pc = w_pc_inc;
    w_taken   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    case (w_op)
      OP_HOLD: w_next_pc = r_pc;
      OP_INC:  w_next_pc = w_pc_inc;
      OP_JMP: begin
        w_next_pc = target_i;
        w_taken   = 1'b1;
      end
      OP_JZ, OP_JNZ, OP_JC: begin
        if (cond_true(w_op, flags_i)) begin
          w_next_pc = target_i;
          w_taken   = 1'b1;
        end else begin
          w_next_pc = w_pc_inc;
        end
      end
      OP_CALL: begin
        w_push = en_i;
        if (!w_full) begin
          w_next_pc = target_i;
          w_taken   = 1'b1;
        end else begin
          w_next_pc = w_pc_inc;
        end
      end
      OP_RET: begin
        w_pop = en_i;
        if (!w_empty) begin
          w_next_pc = w_top;
          w_taken   = 1'b1;
        end else begin
          w_next_pc = w_pc_inc;
        end
      end
      default: w_next_pc = r_pc;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc    <= PC_W'(RESET_VEC);
      r_taken <= 1'b0;
      r_fault <= 1'b0;
    end else if (en_i) begin
      r_pc    <= w_next_pc;
      r_taken <= w_taken;
      r_fault <= r_fault | w_refused;
    end else begin
      r_taken <= 1'b0;
    end
  end

  assign pc_o    = r_pc;
  assign taken_o = r_taken;
  assign fault_o = r_fault;
  assign empty_o = w_empty;
  assign full_o  = w_full;

endmodule
